// File: rtl/stack_pkg.sv
// Shared defaults and FSM state encoding for the stack controller slice.
package stack_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 3;
    localparam int DEPTH_DEF  = 2 ** AWIDTH_DEF;

    // FSM encoding kept as plain 2-bit constants for compatibility with older blocks
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_SWAP  = 2'd3;

endpackage

// File: rtl/stack_if.sv
// Request/response bundle between a stack client (master) and stack_ctrl (slave).
interface stack_if
    import stack_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);

    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] din;
    logic              ready;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;

    modport master (
        output push, pop, din,
        input  ready, dout, dout_valid
    );

    modport slave (
        input  push, pop, din,
        output ready, dout, dout_valid
    );

endinterface

// File: rtl/stack_rf.sv
// DEPTH x DWIDTH stack storage: one synchronous write port, one asynchronous read port
// sharing a single address.
module stack_rf
    import stack_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] addr,
    input  logic              wen,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; the stack pointer decides what is reachable
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller: IDLE/WRITE/READ/SWAP FSM, stack pointer and error flags.
// Optional feature macro: STACK_ERR_FLAGS_EN enables sticky ovf/unf flags cleared by err_clr;
// without it illegal requests are still ignored but ovf/unf read as 0.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_if.slave            bus,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    input  logic              err_clr,
    output logic              ovf,
    output logic              unf
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH + 1)'(DEPTH);

    logic [1:0]        state;
    logic [AWIDTH:0]   sp;
    logic              swap_q;
    logic [DWIDTH-1:0] din_q;
    logic [DWIDTH-1:0] dout_q;
    logic              dout_valid_q;

    logic              idle;
    logic              req_swap;
    logic              req_push;
    logic              req_pop;
    logic              ovf_set;
    logic              unf_set;

    logic [AWIDTH-1:0] sp_lo;
    logic [AWIDTH-1:0] sp_lo_dec;
    logic [AWIDTH-1:0] rf_addr;
    logic              rf_wen;
    logic [DWIDTH-1:0] rf_dout;

    assign count = sp;
    assign full  = (sp == DEPTH_CNT);
    assign empty = (sp == '0);
    assign idle  = (state == ST_IDLE);

    // Request decode; push+pop on an empty stack degrades to a plain push
    assign req_swap = idle & bus.push & bus.pop & ~empty;
    assign req_push = idle & bus.push & (bus.pop ? empty : ~full);
    assign req_pop  = idle & bus.pop & ~bus.push & ~empty;
    assign ovf_set  = idle & bus.push & ~bus.pop & full;
    assign unf_set  = idle & bus.pop & empty;

    // A swap reads and rewrites the top entry (sp-1); a plain push writes at sp,
    // a pop reads at sp after it has already been decremented
    assign sp_lo     = sp[AWIDTH-1:0];
    assign sp_lo_dec = sp_lo - 1'b1;
    assign rf_wen    = (state == ST_WRITE);
    assign rf_addr   = ((state == ST_SWAP) || ((state == ST_WRITE) && swap_q)) ? sp_lo_dec : sp_lo;

    stack_rf #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_rf (
        .clk  (clk),
        .addr (rf_addr),
        .wen  (rf_wen),
        .din  (din_q),
        .dout (rf_dout)
    );

    // Push data is held from the accepting cycle until the WRITE state uses it
    always_ff @(posedge clk) begin
        if (idle && bus.push) begin
            din_q <= bus.din;
        end
    end

    // Main FSM with stack pointer and registered pop data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sp           <= '0;
            swap_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_swap) begin
                        swap_q <= 1'b1;
                        state  <= ST_SWAP;
                    end else if (req_push) begin
                        swap_q <= 1'b0;
                        state  <= ST_WRITE;
                    end else if (req_pop) begin
                        sp    <= sp - 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (!swap_q) begin
                        sp <= sp + 1'b1;
                    end
                    state <= ST_IDLE;
                end
                ST_READ: begin
                    dout_q       <= rf_dout;
                    dout_valid_q <= 1'b1;
                    state        <= ST_IDLE;
                end
                ST_SWAP: begin
                    dout_q       <= rf_dout;
                    dout_valid_q <= 1'b1;
                    state        <= ST_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready      = idle;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

`ifdef STACK_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_err;

    assign ovf        = 1'b0;
    assign unf        = 1'b0;
    assign unused_err = &{1'b0, err_clr, ovf_set, unf_set};
`endif

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl
Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width.
REQ-002 SHALL have parameter AWIDTH, default 3, storage address width; DEPTH = 2**AWIDTH (8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  push request, sampled when ready=1.
REQ-006 SHALL have port pop  input  1  pop request, sampled when ready=1.
REQ-007 SHALL have port din  input  DWIDTH  push data.
REQ-008 SHALL have port ready  output  1  high only in IDLE; request accepted when ready & (push|pop).
REQ-009 SHALL have port dout  output  DWIDTH  popped word, registered.
REQ-010 SHALL have port dout_valid  output  1  one-cycle pulse, dout valid.
REQ-011 SHALL have port count  output  AWIDTH+1  occupancy 0..DEPTH.
REQ-012 SHALL have port full  output  1  count==DEPTH.
REQ-013 SHALL have port empty  output  1  count==0.
REQ-014 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-015 SHALL have port ovf  output  1  sticky overflow flag.
REQ-016 SHALL have port unf  output  1  sticky underflow flag.
Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, SWAP; only IDLE accepts requests.
REQ-018 Push-only accepted at cycle N (not full): din captured; N+1 WRITE, storage write at address sp; sp+1 at end of N+1; back to IDLE.
REQ-019 Pop-only accepted at N (not empty): sp-1 at end of N; N+1 READ, storage read at new sp, dout registered; dout_valid high in N+2.
REQ-020 Push+pop at N, not empty (full included): N+1 SWAP reads sp-1 into dout; N+2 WRITE writes captured din at sp-1; sp unchanged; dout_valid high in N+2.
REQ-021 Push+pop when empty: executed as push-only; unf set.
REQ-022 Push when full (pop=0): ignored, no write, state stays IDLE, ovf set.
REQ-023 Pop when empty (push=0): ignored, no dout_valid, unf set.
REQ-024 Storage write enable SHALL be asserted only in WRITE, exactly one cycle per write.
REQ-025 count SHALL equal sp; full/empty combinational from count; sp never wraps (0..DEPTH).
REQ-026 ovf/unf SHALL stay set until err_clr=1; err_clr same cycle as new error: set wins.
REQ-027 Requests while ready=0 SHALL be ignored with no flag change.
Reset
REQ-028 rst_n low SHALL immediately force state IDLE, sp=0, dout=0, dout_valid=0, ovf=unf=0, write enable low.
REQ-029 Reset mid-WRITE/READ/SWAP SHALL abort the operation; storage contents not cleared, but unreachable (sp=0).
REQ-030 ready SHALL be 1 from the first edge after rst_n release.
Configuration
REQ-031 Macro STACK_ERR_FLAGS_EN defined: ovf/unf/err_clr behave per REQ-021..023, REQ-026.
REQ-032 Macro undefined: illegal requests still ignored identically; ovf/unf tied 0, err_clr unused, no flag flops.
Structure
REQ-033 Package stack_pkg SHALL hold DWIDTH/AWIDTH/DEPTH defaults and the FSM state encoding.
REQ-034 Storage SHALL be one sub-module, stack_rf (DEPTH x DWIDTH, 1 write port, 1 async read port, addr/wen/din/dout).
REQ-035 FSM, sp and flag logic SHALL remain in stack_ctrl; no logic in stack_rf beyond storage.
Verification
REQ-036 Reset, push 0x11,0x22,0x33 -> count=3, empty=0; pops return 0x33,0x22,0x11, each dout_valid 2 cycles after accept.
REQ-037 Push 8 words 0x01..0x08 -> full=1, count=8; 9th push 0xFF -> ignored, ovf=1, pop returns 0x08.
REQ-038 From empty pop -> no dout_valid, unf=1; err_clr -> unf=0 next cycle; push+pop with din=0x5A -> count=1, unf=1.
REQ-039 Stack [0xA0,0xB0], push+pop din=0xC0 -> dout=0xB0 valid at N+2, count=2, next pop returns 0xC0.
REQ-040 rst_n low during WRITE of push 0x77 -> count=0, ready=1 after release, pop -> unf=1, no dout_valid.
REQ-041 Build without STACK_ERR_FLAGS_EN, repeat REQ-037/038 -> ovf=unf=0 always, stack behaviour unchanged.
